// File: rtl/frame_pattern_gen_pkg.sv
// Shared video definitions: pattern modes, FSM states, frame config payload.
`timescale 1ns/1ps
package frame_pattern_gen_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {
    PAT_GRAD  = 2'd0,
    PAT_CONST = 2'd1,
    PAT_CNT   = 2'd2,
    PAT_CHECK = 2'd3
  } pat_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_HSYNC  = 3'd3,
    ST_HBP    = 3'd4,
    ST_ACTIVE = 3'd5
  } state_e;

  // Per-frame settings captured at frame launch
  typedef struct packed {
    pat_mode_e        mode;
    logic [PIX_W-1:0] const_val;
  } frame_cfg_t;

  // Counter width for a count of n items, never below one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_pattern_gen_if.sv
// Control and video bus of the pattern generator.
`timescale 1ns/1ps
interface frame_pattern_gen_if;
  import frame_pattern_gen_pkg::*;

  logic              start;
  logic              loop;
  logic [MODE_W-1:0] mode;
  logic [PIX_W-1:0]  const_val;
  logic              vsync;
  logic              hsync;
  logic [PIX_W-1:0]  pix;
  logic              pix_valid;
  logic              busy;
  logic              frame_done;

  // Generator side: takes control, drives video
  modport master (
    input  start, loop, mode, const_val,
    output vsync, hsync, pix, pix_valid, busy, frame_done
  );

  // Consumer side: drives control, receives video
  modport slave (
    output start, loop, mode, const_val,
    input  vsync, hsync, pix, pix_valid, busy, frame_done
  );

endinterface

// File: rtl/frame_pattern_gen_pixel.sv
// Pixel value for one position of the frame under the selected pattern.
`timescale 1ns/1ps
module frame_pattern_gen_pixel
  import frame_pattern_gen_pkg::*;
#(
  parameter int unsigned PIX_CW  = 3,
  parameter int unsigned LINE_CW = 3
) (
  input  logic               valid,
  input  pat_mode_e          mode,
  input  logic [PIX_W-1:0]   const_val,
  input  logic [PIX_CW-1:0]  pix_idx,
  input  logic [LINE_CW-1:0] line_idx,
  input  logic [PIX_W-1:0]   cnt,
  output logic [PIX_W-1:0]   pix_c
);

  // Pattern select; blank pixels are forced to zero
  always_comb begin
    pix_c = '0;
    if (valid) begin
      case (mode)
        PAT_GRAD:  pix_c = PIX_W'(pix_idx) + PIX_W'(line_idx) + PIX_W'(1);
        PAT_CONST: pix_c = const_val;
        PAT_CNT:   pix_c = cnt;
        PAT_CHECK: pix_c = (pix_idx[0] ^ line_idx[0]) ? '1 : '0;
        default:   pix_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/frame_pattern_gen.sv
// Framed test-pattern source: vsync, then per line hsync + active pixels.
`timescale 1ns/1ps
module frame_pattern_gen
  import frame_pattern_gen_pkg::*;
#(
  parameter int unsigned H_PIX   = 6,
  parameter int unsigned V_LINES = 7,
  parameter int unsigned VS_W    = 1,
  parameter int unsigned V_BP    = 0,
  parameter int unsigned HS_W    = 1,
  parameter int unsigned H_BP    = 0
) (
  input  logic                pclk,
  input  logic                rst_n,
  frame_pattern_gen_if.master vid
);

  localparam int unsigned PIX_CW  = cnt_w(H_PIX);
  localparam int unsigned LINE_CW = cnt_w(V_LINES);
  localparam int unsigned SYNC_MX = (VS_W > HS_W) ? VS_W : HS_W;
  localparam int unsigned BP_MX   = (V_BP > H_BP) ? V_BP : H_BP;
  localparam int unsigned TMR_W   = cnt_w((SYNC_MX > BP_MX) ? SYNC_MX : BP_MX);

  localparam logic [PIX_CW-1:0]  PIX_LAST  = PIX_CW'(H_PIX - 1);
  localparam logic [LINE_CW-1:0] LINE_LAST = LINE_CW'(V_LINES - 1);
  localparam logic [TMR_W-1:0]   VS_LAST   = TMR_W'(VS_W - 1);
  localparam logic [TMR_W-1:0]   VBP_LAST  = TMR_W'(V_BP - 1);
  localparam logic [TMR_W-1:0]   HS_LAST   = TMR_W'(HS_W - 1);
  localparam logic [TMR_W-1:0]   HBP_LAST  = TMR_W'(H_BP - 1);

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [PIX_CW-1:0]    pix_idx_q, pix_idx_d;
  logic [LINE_CW-1:0]   line_idx_q, line_idx_d;
  logic [PIX_W-1:0]     cnt_q, cnt_d;
  frame_cfg_t           cfg_q, cfg_d;
  logic                 launch;
  logic [PIX_W-1:0]     pix_c;

  // Next-state, geometry counters and frame-config capture
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    pix_idx_d  = pix_idx_q;
    line_idx_d = line_idx_q;
    cnt_d      = cnt_q;
    cfg_d      = cfg_q;
    launch     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vid.start) begin
          launch = 1'b1;
        end
      end
      ST_VSYNC: begin
        if (tmr_q == VS_LAST) begin
          tmr_d   = '0;
          state_d = (V_BP == 0) ? ST_HSYNC : ST_VBP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_VBP: begin
        if (tmr_q == VBP_LAST) begin
          tmr_d   = '0;
          state_d = ST_HSYNC;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_HSYNC: begin
        if (tmr_q == HS_LAST) begin
          tmr_d   = '0;
          state_d = (H_BP == 0) ? ST_ACTIVE : ST_HBP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_HBP: begin
        if (tmr_q == HBP_LAST) begin
          tmr_d   = '0;
          state_d = ST_ACTIVE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_ACTIVE: begin
        cnt_d = cnt_q + PIX_W'(1);
        if (pix_idx_q == PIX_LAST) begin
          pix_idx_d = '0;
          if (line_idx_q == LINE_LAST) begin
            state_d = ST_IDLE;
            launch  = vid.loop;
          end else begin
            line_idx_d = line_idx_q + LINE_CW'(1);
            state_d    = ST_HSYNC;
          end
        end else begin
          pix_idx_d = pix_idx_q + PIX_CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Fresh frame: clear geometry, restart the running count, relatch settings
    if (launch) begin
      state_d    = ST_VSYNC;
      tmr_d      = '0;
      pix_idx_d  = '0;
      line_idx_d = '0;
      cnt_d      = '0;
      cfg_d.mode      = pat_mode_e'(vid.mode);
      cfg_d.const_val = vid.const_val;
    end
  end

  // FSM and counter registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      pix_idx_q  <= '0;
      line_idx_q <= '0;
      cnt_q      <= '0;
      cfg_q      <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      pix_idx_q  <= pix_idx_d;
      line_idx_q <= line_idx_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
    end
  end

  frame_pattern_gen_pixel #(
    .PIX_CW  (PIX_CW),
    .LINE_CW (LINE_CW)
  ) u_pixel (
    .valid     (state_d == ST_ACTIVE),
    .mode      (cfg_d.mode),
    .const_val (cfg_d.const_val),
    .pix_idx   (pix_idx_d),
    .line_idx  (line_idx_d),
    .cnt       (cnt_d),
    .pix_c     (pix_c)
  );

  // Output registers loaded from the upcoming state so they align with it
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vid.vsync      <= 1'b0;
      vid.hsync      <= 1'b0;
      vid.pix        <= '0;
      vid.pix_valid  <= 1'b0;
      vid.busy       <= 1'b0;
      vid.frame_done <= 1'b0;
    end else begin
      vid.vsync      <= (state_d == ST_VSYNC);
      vid.hsync      <= (state_d == ST_HSYNC);
      vid.pix        <= pix_c;
      vid.pix_valid  <= (state_d == ST_ACTIVE);
      vid.busy       <= (state_d != ST_IDLE);
      vid.frame_done <= (state_d == ST_ACTIVE) && (pix_idx_d == PIX_LAST) &&
                        (line_idx_d == LINE_LAST);
    end
  end

endmodule

// File: tb/tb_frame_pattern_gen.sv
// Directed bench for frame_pattern_gen: vector table plus corner sequences.
`timescale 1ns/1ps
module tb_frame_pattern_gen;

  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  frame_pattern_gen_if vif0();
  frame_pattern_gen_if vif1();
  frame_pattern_gen_if vif2();

  frame_pattern_gen dut0 (.pclk(pclk), .rst_n(rst_n), .vid(vif0));
  frame_pattern_gen #(.H_PIX(16), .V_LINES(20)) dut1 (.pclk(pclk), .rst_n(rst_n), .vid(vif1));
  frame_pattern_gen #(.VS_W(2), .V_BP(2), .HS_W(2), .H_BP(3)) dut2 (.pclk(pclk), .rst_n(rst_n), .vid(vif2));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        start;
    logic        loop;
    logic [1:0]  mode;
    logic [7:0]  cval;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {vsync, hsync, pix_valid, busy, frame_done, pix}
  function automatic logic [12:0] pk(input logic vs, input logic hs, input logic pv,
                                     input logic bsy, input logic fd, input logic [7:0] px);
    return {vs, hs, pv, bsy, fd, px};
  endfunction

  function automatic logic [12:0] out0();
    return pk(vif0.vsync, vif0.hsync, vif0.pix_valid, vif0.busy, vif0.frame_done, vif0.pix);
  endfunction
  function automatic logic [12:0] out1();
    return pk(vif1.vsync, vif1.hsync, vif1.pix_valid, vif1.busy, vif1.frame_done, vif1.pix);
  endfunction
  function automatic logic [12:0] out2();
    return pk(vif2.vsync, vif2.hsync, vif2.pix_valid, vif2.busy, vif2.frame_done, vif2.pix);
  endfunction

  task automatic chk(input string name, input int idx, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got {vs,hs,pv,busy,fd,pix}=%h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic add_idle();
    vec_t v;
    v.start = 1'b0; v.loop = 1'b0; v.mode = 2'd0; v.cval = 8'h00;
    v.exp = pk(0, 0, 0, 0, 0, 8'h00);
    vecs.push_back(v);
  endtask

  // One default-geometry frame (1 vsync, 7 x (1 hsync + 6 pixels)).
  // Mid-frame rows drive other mode/const values, stray start and loop pulses.
  task automatic add_frame(input logic [1:0] m, input logic [7:0] c, input logic via_loop);
    vec_t v;
    int   k = 0;
    logic [7:0] px;
    v.start = !via_loop; v.loop = via_loop; v.mode = m; v.cval = c;
    v.exp = pk(1, 0, 0, 1, 0, 8'h00);
    vecs.push_back(v);
    for (int l = 0; l < 7; l++) begin
      v.start = (l == 2); v.loop = 1'b0; v.mode = ~m; v.cval = 8'h00;
      v.exp = pk(0, 1, 0, 1, 0, 8'h00);
      vecs.push_back(v);
      for (int p = 0; p < 6; p++) begin
        case (m)
          2'd0:    px = 8'(p + l + 1);
          2'd1:    px = c;
          2'd2:    px = 8'(k);
          default: px = (((p ^ l) & 1) != 0) ? 8'hFF : 8'h00;
        endcase
        v.start = (p == 3); v.loop = (p == 1); v.mode = ~m; v.cval = 8'h00;
        v.exp = pk(0, 0, 1, 1, (l == 6 && p == 5), px);
        vecs.push_back(v);
        k++;
      end
    end
  endtask

  initial begin
    int npix, ncyc, fd_cnt, fd_at;
    logic [12:0] e;

    vif0.start = 0; vif0.loop = 0; vif0.mode = 0; vif0.const_val = 0;
    vif1.start = 0; vif1.loop = 0; vif1.mode = 0; vif1.const_val = 0;
    vif2.start = 0; vif2.loop = 0; vif2.mode = 0; vif2.const_val = 0;

    // Reset state
    repeat (2) @(negedge pclk);
    chk("reset0", 0, out0(), 13'h0);
    chk("reset1", 0, out1(), 13'h0);
    chk("reset2", 0, out2(), 13'h0);
    rst_n = 1'b1;

    // Vector table: gradient, constant with mid-frame change, looped checker and counter
    add_idle();
    add_frame(2'd0, 8'h33, 1'b0);
    add_idle();
    add_idle();
    add_frame(2'd1, 8'hA5, 1'b0);
    add_frame(2'd3, 8'h11, 1'b1);
    add_frame(2'd2, 8'h77, 1'b1);
    add_idle();
    add_idle();
    for (int i = 0; i < vecs.size(); i++) begin
      vif0.start = vecs[i].start; vif0.loop = vecs[i].loop;
      vif0.mode = vecs[i].mode; vif0.const_val = vecs[i].cval;
      @(negedge pclk);
      chk("vec", i, out0(), vecs[i].exp);
    end

    // Reset at line 3 pixel 2, then a clean restart
    vif0.start = 1; vif0.loop = 0; vif0.mode = 2'd0;
    @(negedge pclk);
    vif0.start = 0;
    repeat (25) @(negedge pclk);
    chk("pre_rst", 0, out0(), pk(0, 0, 1, 1, 0, 8'd6));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 0, out0(), 13'h0);
    @(negedge pclk);
    chk("in_rst", 0, out0(), 13'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("post_rst_idle", i, out0(), 13'h0);
    end
    vif0.start = 1;
    @(negedge pclk);
    vif0.start = 0;
    chk("restart_vs", 0, out0(), pk(1, 0, 0, 1, 0, 8'h00));
    for (int l = 0; l < 2; l++) begin
      @(negedge pclk);
      chk("restart_hs", l, out0(), pk(0, 1, 0, 1, 0, 8'h00));
      for (int p = 0; p < 6; p++) begin
        @(negedge pclk);
        chk("restart_pix", l * 6 + p, out0(), pk(0, 0, 1, 1, 0, 8'(p + l + 1)));
      end
    end

    // Counter pattern on a 16x20 frame: wrap at pixel 256, 320 pixels, 341 busy cycles
    vif1.start = 1; vif1.mode = 2'd2;
    @(negedge pclk);
    vif1.start = 0;
    chk("cnt_vs", 0, out1(), pk(1, 0, 0, 1, 0, 8'h00));
    npix = 0; ncyc = 1; fd_cnt = 0; fd_at = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge pclk);
      if (!vif1.busy) break;
      ncyc++;
      if (vif1.pix_valid) begin
        chk("cnt_pix", npix, {5'b0, vif1.pix}, {5'b0, 8'(npix)});
        npix++;
      end else begin
        chk("cnt_blank", ncyc, {5'b0, vif1.pix}, 13'h0);
      end
      if (vif1.frame_done) begin
        fd_cnt++;
        fd_at = npix;
      end
    end
    chk_i("cnt_total_pix", npix, 320);
    chk_i("cnt_frame_len", ncyc, 341);
    chk_i("cnt_fd_count", fd_cnt, 1);
    chk_i("cnt_fd_pos", fd_at, 320);

    // Porches and wider syncs with checker pattern: frame length 4 + 7*11 = 81
    vif2.start = 1; vif2.mode = 2'd3;
    for (int c = 1; c <= 82; c++) begin
      @(negedge pclk);
      vif2.start = 0;
      if (c <= 2) e = pk(1, 0, 0, 1, 0, 8'h00);
      else if (c <= 4) e = pk(0, 0, 0, 1, 0, 8'h00);
      else if (c <= 81) begin
        int o, l, p;
        o = (c - 5) % 11;
        l = (c - 5) / 11;
        p = o - 5;
        if (o < 2) e = pk(0, 1, 0, 1, 0, 8'h00);
        else if (o < 5) e = pk(0, 0, 0, 1, 0, 8'h00);
        else e = pk(0, 0, 1, 1, (l == 6 && p == 5), (((p ^ l) & 1) != 0) ? 8'hFF : 8'h00);
      end else e = 13'h0;
      chk("porch", c, out2(), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
